// File: rtl/gray_rx.sv
// Gray-code counter receiver: synchronises a 4-bit reflected Gray count, decodes it,
// classifies each transition and keeps a wrapping net-position count with fault recovery.
module gray_rx #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned POS_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 clr_err,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 step_up,
   output logic                 step_dn,
   output logic                 err,
   output logic                 err_sticky,
   output logic [POS_WIDTH-1:0] pos,
   output logic                 tracking
);

   localparam int unsigned CNT_W  = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
   localparam int unsigned FLIP_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   fill_cnt;
   logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]   g_prev;

   logic [WIDTH-1:0]   g_cur;
   logic [WIDTH-1:0]   cur_bin;
   logic [WIDTH-1:0]   prev_bin;
   logic [FLIP_W-1:0]  flips;
   logic               is_step;
   logic               is_illegal;
   logic               is_up;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Transition classification between the newest synchronised value and the last accepted one
   assign g_cur      = sync_q[SYNC_STAGES-1];
   assign cur_bin    = gray2bin(g_cur);
   assign prev_bin   = gray2bin(g_prev);
   assign flips      = FLIP_W'($countones(g_cur ^ g_prev));
   assign is_step    = (flips == FLIP_W'(1));
   assign is_illegal = (flips > FLIP_W'(1));
   assign is_up      = (cur_bin == prev_bin + WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
         end
         state      <= INIT;
         fill_cnt   <= '0;
         g_prev     <= '0;
         bin_out    <= '0;
         step_up    <= 1'b0;
         step_dn    <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         pos        <= '0;
         tracking   <= 1'b0;
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         step_up <= 1'b0;
         step_dn <= 1'b0;
         err     <= 1'b0;

         case (state)
            INIT: begin
               if (clr_err) err_sticky <= 1'b0;
               // Wait until the synchroniser holds real samples before accepting a reference
               if (fill_cnt == CNT_W'(SYNC_STAGES - 1)) begin
                  g_prev   <= g_cur;
                  bin_out  <= cur_bin;
                  state    <= TRACK;
                  tracking <= 1'b1;
               end else begin
                  fill_cnt <= fill_cnt + CNT_W'(1);
               end
            end

            TRACK: begin
               g_prev  <= g_cur;
               bin_out <= cur_bin;
               if (is_illegal) begin
                  err        <= 1'b1;
                  err_sticky <= 1'b1;
                  state      <= FAULT;
                  tracking   <= 1'b0;
               end else begin
                  if (clr_err) err_sticky <= 1'b0;
                  if (is_step && is_up) begin
                     step_up <= 1'b1;
                     pos     <= pos + POS_WIDTH'(1);
                  end else if (is_step) begin
                     step_dn <= 1'b1;
                     pos     <= pos - POS_WIDTH'(1);
                  end
               end
            end

            FAULT: begin
               bin_out <= cur_bin;
               if (clr_err) begin
                  err_sticky <= 1'b0;
                  g_prev     <= g_cur;
                  state      <= TRACK;
                  tracking   <= 1'b1;
               end
            end

            default: begin
               state    <= INIT;
               tracking <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gray_rx.md
# gray_rx

Receiving end of the Gray-code counter interface. Takes a free-running 4-bit reflected Gray count from an asynchronous or same-clock source and synchronises it. Decodes it to binary and classifies every transition as up-step, down-step or illegal jump. Keeps a wrapping net-position accumulator and a sticky fault flag, and recovers from faults under software control.

## Interface
- WIDTH, 4, Gray/binary word width
- SYNC_STAGES, 2, synchroniser flops on gray_in (≥1)
- POS_WIDTH, 8, net-position accumulator width

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- gray_in  input  WIDTH  Gray count from transmitter (may be asynchronous)
- clr_err  input  1  single-cycle request: clear fault and resynchronise
- bin_out  output  WIDTH  binary decode of synchronised Gray value
- step_up  output  1  one-cycle pulse per +1 step
- step_dn  output  1  one-cycle pulse per −1 step
- err  output  1  one-cycle pulse on illegal transition
- err_sticky  output  1  high from illegal transition until clr_err
- pos  output  POS_WIDTH  up count minus down count, modulo 2^POS_WIDTH
- tracking  output  1  high in TRACK state

## Operation
- Sync chain sync[0..SYNC_STAGES-1] shifts gray_in every cycle. g_cur = sync[SYNC_STAGES-1].
- g_prev register holds the last accepted g_cur.
- Decode: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
- Transition class from popcount(g_cur ^ g_prev):
  - 0: hold.
  - 1: step. Up if dec(g_cur) == dec(g_prev)+1 mod 2^WIDTH, otherwise down.
  - ≥2: illegal.
- FSM states:
  - INIT: entered on reset. A fill counter counts SYNC_STAGES cycles. On the last count, load g_prev ← g_cur and bin_out ← dec(g_cur), then go to TRACK. No pulses in INIT.
  - TRACK: every cycle, g_prev ← g_cur and bin_out ← dec(g_cur).
    - Step: pulse step_up or step_dn; pos ± 1, wrapping.
    - Illegal: pulse err, set err_sticky, go to FAULT. pos unchanged.
  - FAULT: bin_out still follows dec(g_cur). No step or err pulses. pos frozen.
    - clr_err: clear err_sticky, load g_prev ← g_cur, go to TRACK.
- clr_err in INIT or TRACK: clears err_sticky (already 0). Otherwise ignored.
- clr_err coinciding with an illegal transition in TRACK: error wins. err pulses, err_sticky = 1, state goes to FAULT.
- step_up, step_dn and err are mutually exclusive.

## Timing
- Reset values:
  - sync chain, g_prev, bin_out = 0
  - step_up, step_dn, err, err_sticky = 0
  - pos = 0
  - tracking = 0
  - state = INIT, fill counter = 0
- rst is sampled at the clock edge only. rst asserted mid-operation returns everything to the reset values on that edge, including pos and err_sticky.
- Latency: gray_in captured at edge N gives bin_out and pulses registered at edge N+SYNC_STAGES. With the default 2, that is the 3rd edge counting the capture edge.
- TRACK is entered SYNC_STAGES cycles after rst deasserts. tracking rises the same edge.
- All outputs are registered. Pulses last exactly one cycle per transition. A value held for k cycles produces one pulse, not k.
- Wrap-around:
  - Gray 1000 (bin 15) → 0000 (bin 0) is step_up. The reverse is step_dn.
  - pos 255 + up = 0; pos 0 + down = 255.
- FAULT → TRACK takes one cycle after clr_err. The first step can be reported on the cycle after that.

## Test plan
- Reset then up-count: drive the Gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0, one value per clock → 16 step_up pulses, bin_out 0..15 then 0, pos = 16, err never high.
- Down-count with wrap: start at 0, drive 8,9,11,10 → 4 step_dn pulses, bin_out 15,14,13,12, pos = 252.
- Hold and slow source: hold each value 10 cycles while counting 0→6 (Gray) → exactly 4 step_up pulses, pos = 4, no extra pulses while held.
- Illegal jump: in TRACK at Gray 0, drive 3 (two bits changed) → err one-cycle pulse, err_sticky = 1, tracking = 0, bin_out = 2, pos unchanged. Further legal steps give no pulses. clr_err → tracking = 1 next cycle, and the next legal step pulses.
- Simultaneous clr_err and illegal jump in TRACK → err pulses, err_sticky stays 1, state is FAULT.
- Reset mid-count: pos = 5 with err_sticky = 1, assert rst one cycle → every output 0 next edge. tracking returns to 1 SYNC_STAGES cycles after release.
